mux_4x1: RTL and testbench
==========================

# mux_4x1

4-to-1 selector: one of four input lanes is chosen by a 2-bit select code. The combinational output O follows the inputs with no clock involved. A registered copy, O_q, is also provided for downstream logic that needs a flopped value. It is a leaf datapath primitive used wherever a small, one-hot-free lane select is needed.

## Interface
- DATA_W, default 1: width of each input lane and of both outputs.
- clk  input  1  rising-edge clock; used only by the O_q register.
- rst  input  1  asynchronous, active-high reset; clears O_q.
- S  input  2  select code; S=0 selects lane 0 … S=3 selects lane 3.
- I  input  4*DATA_W  packed lanes; lane k occupies bits [k*DATA_W +: DATA_W]. With DATA_W=1 this is I[3:0] and lane k = I[k].
- O  output  DATA_W  combinational selected lane.
- O_q  output  DATA_W  registered selected lane.
- Port order for positional instantiation: S, I, O, then clk, rst, O_q.
- One clock; reset is asynchronous and active-high.

## Operation
- O = lane[S]:
  - S=00 → I lane 0
  - S=01 → lane 1
  - S=10 → lane 2
  - S=11 → lane 3
- O is purely combinational.
  - It is sensitive to every bit of S and I.
  - Any change on either settles O in the same delta/time step.
  - O does not depend on clk or rst.
  - O is not cleared by reset.
- All four select codes are legal. There is no default or error case.
- O_q register:
  - On every rising clk edge with rst low, O_q ← lane[S] as sampled at that edge.
  - While rst is high, O_q = 0 (all DATA_W bits).
  - The clear is asynchronous: O_q drops to 0 immediately when rst rises, without waiting for a clock edge.
- Width rule: the selected lane is copied bit-for-bit. There is no extension or truncation, and lanes never mix.
- Unknown select (X/Z on S) must not be silently mapped to a lane. O is X in simulation.

## Timing
- O: zero-cycle latency, combinational path S→O and I→O. There is no register on this path.
- O_q: one-cycle latency. O_q at edge n+1 reflects S and I sampled at edge n.
- Reset value: O_q = 0. O has no reset value; it tracks its inputs.
- Reset deassertion: synchronous release is not required. The first capture is on the first rising edge after rst falls.
- Reset asserted mid-operation: O_q clears asynchronously. O keeps tracking its inputs throughout.
- Simultaneous S and I change: O reflects the new pair once both settle. O_q captures whatever is stable at the clock edge.
- No handshake and no backpressure.

## Test plan
- Combinational select, with clk idle and rst low:
  - I=1011, S=00 → O=1
  - I=1011, S=10 → O=0
- Data change under fixed select: S=10, I changes 1011→0100 → O goes 0→1 immediately, with no clock.
- Remaining codes with I=0100:
  - S=11 → O=0
  - S=01 → O=0
- Exhaustive check: all 16 I values × 4 S values → O == I[S] every time.
- Register path:
  - Assert rst → O_q=0 immediately, before any clk edge.
  - Release rst; set I=1000, S=11 → O_q=1 after the next rising edge.
  - Set S=00 → O_q=0 one edge later.
- Async reset mid-run:
  - With O_q=1, raise rst between clock edges → O_q=0 at once, while O still shows I[S].
  - Lower rst → capture resumes on the next edge.

Source files
------------

// File: rtl/mux_4x1.sv
// 4-to-1 lane selector: combinational output O plus a flopped copy O_q.
// O_q clears asynchronously on rst; O tracks S and I with no clock involvement.
module mux_4x1 #(
  parameter int DATA_W = 1
) (
  input  logic [1:0]          S,
  input  logic [4*DATA_W-1:0] I,
  output logic [DATA_W-1:0]   O,
  input  logic                clk,
  input  logic                rst,
  output logic [DATA_W-1:0]   O_q
);

  logic [DATA_W-1:0] sel_d;
  logic [DATA_W-1:0] out_q;

  // Lane select; an unknown select propagates X instead of aliasing to a lane
  always_comb begin
    sel_d = '0;
    case (S)
      2'd0:    sel_d = I[0*DATA_W +: DATA_W];
      2'd1:    sel_d = I[1*DATA_W +: DATA_W];
      2'd2:    sel_d = I[2*DATA_W +: DATA_W];
      2'd3:    sel_d = I[3*DATA_W +: DATA_W];
      default: sel_d = 'x;
    endcase
  end

  assign O = sel_d;

  // Output register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= sel_d;
    end
  end

  assign O_q = out_q;

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: directed select/reset cases plus randomized
// traffic on a 1-bit and a 4-bit instance, checked against a shift-and-mask model.
module tb_mux_4x1;

  logic        clk;
  logic        rst;
  logic [1:0]  S;
  logic [3:0]  I;
  logic [0:0]  O;
  logic [0:0]  O_q;
  logic [15:0] I_w;
  logic [3:0]  O_w;
  logic [3:0]  O_q_w;

  int checks;
  int errors;

  mux_4x1 #(.DATA_W(1)) dut (
    .S   (S),
    .I   (I),
    .O   (O),
    .clk (clk),
    .rst (rst),
    .O_q (O_q)
  );

  mux_4x1 #(.DATA_W(4)) dut_w (
    .S   (S),
    .I   (I_w),
    .O   (O_w),
    .clk (clk),
    .rst (rst),
    .O_q (O_q_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lane s of a packed word is the w bits starting at s*w
  function automatic logic [31:0] ref_sel(input logic [1:0] s, input logic [31:0] lanes,
                                          input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (lanes >> (int'(s) * w)) & mask;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0]  s_smp;
  logic [3:0]  i_smp;
  logic [15:0] iw_smp;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    S   = 2'd0;
    I   = 4'd0;
    I_w = 16'd0;
    #1;
    check("reset_oq", 32'(O_q), 32'd0);
    check("reset_oq_w", 32'(O_q_w), 32'd0);

    // Combinational select, independent of the clock
    I = 4'b1011; S = 2'b00; #1;
    check("comb_s0", 32'(O), 32'd1);
    S = 2'b10; #1;
    check("comb_s2", 32'(O), 32'd0);
    I = 4'b0100; #1;
    check("data_change_s2", 32'(O), 32'd1);
    S = 2'b11; #1;
    check("comb_s3", 32'(O), 32'd0);
    S = 2'b01; #1;
    check("comb_s1", 32'(O), 32'd0);

    for (int iv = 0; iv < 16; iv++) begin
      for (int sv = 0; sv < 4; sv++) begin
        I = 4'(iv);
        S = 2'(sv);
        #1;
        check("exhaustive", 32'(O), ref_sel(S, 32'(I), 1));
      end
    end

    // Register held at zero while rst stays high across an edge
    @(negedge clk);
    I = 4'b1000; S = 2'b11;
    @(posedge clk); #1;
    check("oq_held_in_reset", 32'(O_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("oq_capture_s3", 32'(O_q), 32'd1);
    @(negedge clk);
    S = 2'b00; #1;
    check("oq_latency", 32'(O_q), 32'd1);
    @(posedge clk); #1;
    check("oq_capture_s0", 32'(O_q), 32'd0);

    // Async clear mid-run
    @(negedge clk);
    S = 2'b11;
    @(posedge clk); #1;
    check("oq_before_async", 32'(O_q), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    check("oq_async_clear", 32'(O_q), 32'd0);
    check("o_during_reset", 32'(O), 32'd1);
    @(negedge clk);
    rst = 1'b0; #1;
    check("oq_after_release", 32'(O_q), 32'd0);
    @(posedge clk); #1;
    check("oq_resume", 32'(O_q), 32'd1);

    // Randomized traffic with occasional async reset pulses
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      S   = 2'($urandom_range(0, 3));
      I   = 4'($urandom);
      I_w = 16'($urandom);
      #1;
      check("rand_o", 32'(O), ref_sel(S, 32'(I), 1));
      check("rand_o_w", 32'(O_w), ref_sel(S, 32'(I_w), 4));
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1; #1;
        check("rand_async_clr", 32'(O_q), 32'd0);
        check("rand_async_clr_w", 32'(O_q_w), 32'd0);
        rst = 1'b0;
      end
      s_smp  = S;
      i_smp  = I;
      iw_smp = I_w;
      @(posedge clk); #1;
      check("rand_oq", 32'(O_q), ref_sel(s_smp, 32'(i_smp), 1));
      check("rand_oq_w", 32'(O_q_w), ref_sel(s_smp, 32'(iw_smp), 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
